// File: rtl/mdu_pkg.sv
// Shared MDU constants: operation encodings, default latencies and op-class helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MFHI  = 4'd5,
        MDOP_MFLO  = 4'd6,
        MDOP_MTHI  = 4'd7,
        MDOP_MTLO  = 4'd8
    } mdop_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Multi-cycle arithmetic ops (MULT, MULTU, DIV, DIVU).
    function automatic logic is_long_op(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
    endfunction

    // Any real MDU op (everything except NONE and undefined codes).
    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_MTLO);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle MULT/DIV with HI/LO registers and D-stage stall request.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_idle_start;
    logic             w_accept_long;
    logic             w_is_mult;
    logic             w_finish;
    logic             w_div_zero;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_div_b;
    logic [31:0]      w_quot_s;
    logic [31:0]      w_rem_s;
    logic [31:0]      w_quot_u;
    logic [31:0]      w_rem_u;
    logic [31:0]      w_pend_hi;
    logic [31:0]      w_pend_lo;

    assign w_idle_start  = start & ~r_busy;
    assign w_accept_long = w_idle_start & is_long_op(mdop);
    assign w_is_mult     = (mdop == MDOP_MULT) || (mdop == MDOP_MULTU);
    assign w_finish      = r_busy && (r_cnt == CNT_W'(1));
    assign w_div_zero    = (r_b == 32'd0) && ((r_op == MDOP_DIV) || (r_op == MDOP_DIVU));

    // Arithmetic on latched operands; divisor forced to 1 on zero so results stay defined
    // (they are never committed in that case).
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_div_b  = (r_b == 32'd0) ? 32'd1 : r_b;
    assign w_quot_s = $signed(r_a) / $signed(w_div_b);
    assign w_rem_s  = $signed(r_a) % $signed(w_div_b);
    assign w_quot_u = r_a / w_div_b;
    assign w_rem_u  = r_a % w_div_b;

    // Select the pending HI/LO result for the latched operation.
    always_comb begin
        w_pend_hi = 32'd0;
        w_pend_lo = 32'd0;
        case (r_op)
            MDOP_MULT: begin
                w_pend_hi = w_prod_s[63:32];
                w_pend_lo = w_prod_s[31:0];
            end
            MDOP_MULTU: begin
                w_pend_hi = w_prod_u[63:32];
                w_pend_lo = w_prod_u[31:0];
            end
            MDOP_DIV: begin
                w_pend_hi = w_rem_s;
                w_pend_lo = w_quot_s;
            end
            MDOP_DIVU: begin
                w_pend_hi = w_rem_u;
                w_pend_lo = w_quot_u;
            end
            default: begin
                w_pend_hi = 32'd0;
                w_pend_lo = 32'd0;
            end
        endcase
    end

    // Busy/counter sequencing and operand latch; starts while busy are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= 4'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
        end else if (r_busy) begin
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (w_accept_long) begin
            r_busy <= 1'b1;
            r_op   <= mdop;
            r_a    <= a;
            r_b    <= b;
            r_cnt  <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
    end

    // HI/LO update: commit pending result on the final busy edge, or direct MTHI/MTLO writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_finish) begin
            if (!w_div_zero) begin
                r_hi <= w_pend_hi;
                r_lo <= w_pend_lo;
            end
        end else if (w_idle_start && (mdop == MDOP_MTHI)) begin
            r_hi <= a;
        end else if (w_idle_start && (mdop == MDOP_MTLO)) begin
            r_lo <= a;
        end
    end

    // Move-from result for the E-stage result mux; zero for anything else.
    always_comb begin
        out = 32'd0;
        if (start) begin
            case (mdop)
                MDOP_MFHI: out = r_hi;
                MDOP_MFLO: out = r_lo;
                default:   out = 32'd0;
            endcase
        end else begin
            out = 32'd0;
        end
    end

    assign busy      = r_busy;
    assign stall_req = start & is_mdu_op(mdop) & (r_busy | is_long_op(mdop));

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops against an arithmetic model.
module tb_mdu;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] out;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdop      (mdop),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .stall_req (stall_req),
        .out       (out)
    );

    always #5 clk = ~clk;

    // Reference model: results from the arithmetic definitions using 64-bit math.
    task automatic model_long(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, q, r, ax, ay;
        longint unsigned ux, uy, p, uq, ur;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            4'd1: begin
                q = sx * sy;
                hi_m = q[63:32];
                lo_m = q[31:0];
            end
            4'd2: begin
                p = ux * uy;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            4'd3: begin
                if (y != 32'd0) begin
                    ax = (sx < 0) ? -sx : sx;
                    ay = (sy < 0) ? -sy : sy;
                    q  = ax / ay;
                    if ((sx < 0) != (sy < 0)) q = -q;
                    r  = sx - q * sy;
                    hi_m = r[31:0];
                    lo_m = q[31:0];
                end
            end
            4'd4: begin
                if (y != 32'd0) begin
                    uq = ux / uy;
                    ur = ux - uq * uy;
                    hi_m = ur[31:0];
                    lo_m = uq[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Issue one multi-cycle op; mode 0: idle while busy, 1: random intruding starts, 2: MTHI then DIV.
    task automatic do_long(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input int mode);
        int          n;
        logic [31:0] old_hi;
        n      = (op == 4'd1 || op == 4'd2) ? NM : ND;
        old_hi = hi_m;
        start = 1'b1; mdop = op; a = x; b = y;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin failures++; $display("FAIL accept_stall op=%0d got=%b want=1", op, stall_req); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL accept_busy op=%0d got=%b want=0", op, busy); end
        @(posedge clk); #1;
        model_long(op, x, y);
        for (int i = 0; i < n; i++) begin
            if (mode == 1) begin
                start = 1'b1; mdop = 4'($urandom_range(1, 8)); a = $urandom; b = $urandom;
            end else if (mode == 2) begin
                start = 1'b1; a = (i == 0) ? 32'h0000_1234 : 32'd9; b = 32'd3;
                mdop = (i == 0) ? 4'd7 : ((i == 1) ? 4'd3 : 4'd5);
            end else begin
                start = 1'b0; mdop = 4'd0;
            end
            #1;
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL busy_cycle op=%0d cyc=%0d got=%b want=1", op, i, busy); end
            if (mode != 0) begin
                checks++;
                if (stall_req !== 1'b1) begin failures++; $display("FAIL busy_stall op=%0d cyc=%0d got=%b want=1", op, i, stall_req); end
                if (mdop == 4'd5) begin
                    checks++;
                    if (out !== old_hi) begin failures++; $display("FAIL hi_hold op=%0d cyc=%0d got=%h want=%h", op, i, out, old_hi); end
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mdop = 4'd0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_fall op=%0d got=%b want=0", op, busy); end
        start = 1'b1; mdop = 4'd5;
        #1;
        checks++;
        if (out !== hi_m) begin failures++; $display("FAIL result_hi op=%0d a=%h b=%h got=%h want=%h", op, x, y, out, hi_m); end
        checks++;
        if (stall_req !== 1'b0) begin failures++; $display("FAIL mf_stall op=%0d got=%b want=0", op, stall_req); end
        mdop = 4'd6;
        #1;
        checks++;
        if (out !== lo_m) begin failures++; $display("FAIL result_lo op=%0d a=%h b=%h got=%h want=%h", op, x, y, out, lo_m); end
        start = 1'b0; mdop = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdop = 4'd0; a = 32'd0; b = 32'd0;
        #2;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_req); end
        checks++;
        if (out !== 32'd0) begin failures++; $display("FAIL reset_out got=%h want=0", out); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mdop = 4'd5;
        #1;
        checks++;
        if (out !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=0", out); end
        mdop = 4'd6;
        #1;
        checks++;
        if (out !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=0", out); end
        start = 1'b0; mdop = 4'd0;
    endtask

    task automatic test_directed();
        do_long(4'd1, 32'hFFFF_FFFD, 32'd7, 0);
        do_long(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        do_long(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        do_long(4'd4, 32'd7, 32'd0, 0);
        do_long(4'd3, 32'd7, 32'd0, 1);
    endtask

    task automatic test_busy_ignore();
        do_long(4'd1, 32'h0001_0003, 32'h0002_0005, 2);
    endtask

    task automatic test_mt_mf();
        @(posedge clk); #1;
        start = 1'b1; mdop = 4'd8; a = 32'hCAFE_BABE;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin failures++; $display("FAIL mtlo_stall got=%b want=0", stall_req); end
        @(posedge clk); #1;
        lo_m = 32'hCAFE_BABE;
        mdop = 4'd6;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b want=0", busy); end
        checks++;
        if (out !== lo_m) begin failures++; $display("FAIL mflo got=%h want=%h", out, lo_m); end
        mdop = 4'd7; a = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        hi_m = 32'h5A5A_0F0F;
        mdop = 4'd5;
        #1;
        checks++;
        if (out !== hi_m) begin failures++; $display("FAIL mfhi got=%h want=%h", out, hi_m); end
        start = 1'b0; mdop = 4'd0;
        #1;
        checks++;
        if (out !== 32'd0) begin failures++; $display("FAIL out_idle got=%h want=0", out); end
    endtask

    task automatic test_back_to_back();
        do_long(4'd2, $urandom, $urandom, 0);
        do_long(4'd3, $urandom, 32'd13, 0);
        do_long(4'd1, $urandom, $urandom, 1);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; mdop = 4'd3; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; mdop = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b want=1", busy); end
        reset = 1'b1; start = 1'b1; mdop = 4'd5;
        hi_m = 32'd0; lo_m = 32'd0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        checks++;
        if (out !== 32'd0) begin failures++; $display("FAIL mid_reset_hi got=%h want=0", out); end
        mdop = 4'd6;
        #1;
        checks++;
        if (out !== 32'd0) begin failures++; $display("FAIL mid_reset_lo got=%h want=0", out); end
        start = 1'b0; mdop = 4'd0;
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_after_busy got=%b want=0", busy); end
        for (int i = 0; i < ND; i++) begin
            @(posedge clk);
        end
        #1;
        start = 1'b1; mdop = 4'd6;
        #1;
        checks++;
        if (out !== lo_m) begin failures++; $display("FAIL mid_discard_lo got=%h want=%h", out, lo_m); end
        start = 1'b0; mdop = 4'd0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] x, y;
        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(0, 8));
            x  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == 4'd3 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd1;
            if (op >= 4'd1 && op <= 4'd4) begin
                do_long(op, x, y, int'($urandom_range(0, 1)));
            end else if (op == 4'd7 || op == 4'd8) begin
                @(posedge clk); #1;
                start = 1'b1; mdop = op; a = x;
                #1;
                checks++;
                if (stall_req !== 1'b0) begin failures++; $display("FAIL rnd_mt_stall op=%0d got=%b want=0", op, stall_req); end
                @(posedge clk); #1;
                if (op == 4'd7) hi_m = x; else lo_m = x;
                start = 1'b0; mdop = 4'd0;
            end else begin
                @(posedge clk); #1;
                start = 1'($urandom_range(0, 1)); mdop = op; a = x; b = y;
                #1;
                checks++;
                if (stall_req !== 1'b0) begin failures++; $display("FAIL rnd_idle_stall op=%0d got=%b want=0", op, stall_req); end
                checks++;
                if (out !== ((start && op == 4'd5) ? hi_m : ((start && op == 4'd6) ? lo_m : 32'd0))) begin
                    failures++; $display("FAIL rnd_out op=%0d start=%b got=%h hi=%h lo=%h", op, start, out, hi_m, lo_m);
                end
                @(posedge clk); #1;
                start = 1'b0; mdop = 4'd0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_mt_mf();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 start  in  1  E-stage instruction is an MDU op; qualifies mdop.
REQ-006 mdop  in  4  op: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
REQ-007 a  in  32  rs operand (forwarded value).
REQ-008 b  in  32  rt operand (forwarded value).
REQ-009 busy  out  1  multi-cycle op in progress.
REQ-010 stall_req  out  1  to hazard unit: stall the D stage when an MDU op is in E and the unit is busy or being started.
REQ-011 out  32  out  HI for MFHI, LO for MFLO, else 0; feeds the E-stage result mux.

Function
REQ-012 MULT/MULTU/DIV/DIVU are accepted on a clk edge only when start=1 and busy=0.
- Operands are latched and the result is computed into pending registers.
- A down-counter is loaded with MULT_CYCLES or DIV_CYCLES; busy goes 1.
REQ-013 While busy=1, the counter decrements each edge.
- On the edge where the counter equals 1: HI/LO are loaded from pending and busy goes 0.
- busy is therefore high for exactly N cycles after the accept edge.
REQ-014 HI/LO hold their old values while busy=1; new results are visible the cycle busy falls.
REQ-015 MULT: signed 32x32, 64-bit product; HI=product[63:32], LO=product[31:0]. MULTU: same, unsigned.
REQ-016 DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
REQ-017 Divide by zero: the counter and busy run the full DIV_CYCLES, but HI/LO are left unchanged.
REQ-018 MTHI/MTLO with start=1 and busy=0 write a to HI/LO on that edge, with no busy period.
REQ-019 Any start while busy=1 (any op, including MTHI/MTLO) has no effect on state.
REQ-020 MFHI/MFLO drive out combinationally from current HI/LO; they are legal only when busy=0 (the stall guarantees this).
REQ-021 stall_req = start & (mdop in MULT..MTLO) & (busy | mdop in MULT..DIVU).
- stall_req covers the accept cycle plus all busy cycles.
REQ-022 mdop=NONE, or start=0, causes no state change.

Reset
REQ-023 While reset=1: busy=0, counter=0, HI=0, LO=0, pending=0, stall_req=0 (given start=0), out=0 (given start=0).
REQ-024 Reset asserted mid-operation aborts the operation immediately; the pending result is discarded.

Structure
REQ-025 mdop encodings and the MULT_CYCLES/DIV_CYCLES defaults belong in the shared constants file used by the control unit.
REQ-026 Single module, no sub-module.
- The control unit supplies mdop from the E-stage decode.
- Arithmetic uses the synthesizable * and / / % operators on latched operands.

Verification
REQ-027 MULT a=0xFFFFFFFD, b=7 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-028 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Then DIVU a=7, b=0 -> busy for 10 cycles, HI/LO unchanged.
REQ-030 During MULT busy, start MTHI a=0x1234 and start DIV -> both ignored.
- HI/LO equal the MULT result after busy falls.
- stall_req=1 throughout.
REQ-031 DIV accepted, reset pulsed on the 3rd busy cycle -> busy=0 and HI=LO=0 immediately, without waiting for a clk edge.
REQ-032 MTLO a=0xCAFEBABE, then MFLO next cycle -> out=0xCAFEBABE, busy never asserted.
